// File: rtl/wbuf_pkg.sv
// Shared weight-buffer constants and the weight_loader state encoding.
// Geometry: 32 x 64-bit weight BRAMs, fed 256 bits (one group of four) per DDR beat.
// Imported by weight_loader and by the weight buffer instance beside it.
package wbuf_pkg;

  localparam int ADDR_LEN     = 16;
  localparam int DATA_LEN     = 64;
  localparam int DDR_DATA_LEN = 256;
  localparam int BUFFER_NUM   = 32;
  localparam int GRP_SIZE     = DDR_DATA_LEN / DATA_LEN;  // BRAMs written per beat
  localparam int GROUPS       = BUFFER_NUM / GRP_SIZE;    // beats per buffer row
  localparam int GRP_W        = $clog2(GROUPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wl_state_t;

endpackage

// File: rtl/weight_loader.sv
// Purpose: scatter a 256-bit DDR beat stream into weight BRAM groups, row by row.
// Latency: beat accepted at t -> wr_en/data_wr/wr_addr at t+1; done at t+2 after the final beat.
// Backpressure: s_ready = (state==LOAD), independent of s_valid; cfg_ready = (state==IDLE), no queueing.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   cfg_valid/cfg_ready    load command handshake; cfg_base_addr = first row, cfg_rows = row count (0..2^ADDR_LEN)
//   s_data/s_valid/s_ready weight beat stream
//   data_wr, wr_addr,      registered write port to the weight buffer; wr_en enables one group
//   wr_en                  of GRP_SIZE BRAMs per accepted beat, zero otherwise
//   busy, done             busy while a load is in flight; done pulses once after the last write
module weight_loader
  import wbuf_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ADDR_LEN-1:0]       cfg_base_addr,
  input  logic [ADDR_LEN:0]         cfg_rows,
  input  logic [DDR_DATA_LEN-1:0]   s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DDR_DATA_LEN-1:0]   data_wr,
  output logic [ADDR_LEN-1:0]       wr_addr,
  output logic [BUFFER_NUM-1:0]     wr_en,
  output logic                      busy,
  output logic                      done
);

  localparam logic [GRP_W-1:0]      LAST_GRP = GRP_W'(GROUPS - 1);
  localparam logic [ADDR_LEN:0]     ONE_ROW  = (ADDR_LEN + 1)'(1);
  localparam logic [BUFFER_NUM-1:0] GRP_MASK = BUFFER_NUM'({GRP_SIZE{1'b1}});

  wl_state_t            state;
  logic [GRP_W-1:0]     grp;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [ADDR_LEN:0]    rows_left;  // rows still to fill, including the one in progress

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grp       <= '0;
      addr_q    <= '0;
      rows_left <= '0;
      wr_en     <= '0;
      data_wr   <= '0;
      wr_addr   <= '0;
    end else begin
      // Enables are a single-cycle strobe; data and address hold between beats.
      wr_en <= '0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            addr_q    <= cfg_base_addr;
            rows_left <= cfg_rows;
            grp       <= '0;
            // A zero-row command completes without ever opening the beat stream.
            state     <= (cfg_rows == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (s_valid) begin
            wr_en   <= GRP_MASK << (grp * GRP_SIZE);
            data_wr <= s_data;  // buffer replicates across groups; no lane shift here
            wr_addr <= addr_q;
            if (grp == LAST_GRP) begin
              grp       <= '0;
              addr_q    <= addr_q + 1'b1;  // wraps at 2^ADDR_LEN
              rows_left <= rows_left - 1'b1;
              if (rows_left == ONE_ROW) state <= DRAIN;
            end else begin
              grp <= grp + 1'b1;
            end
          end
        end
        // The final write is on the bus during DRAIN; done follows once it has committed.
        DRAIN:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg_ready = (state == IDLE);
  assign s_ready   = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: a per-cycle vector table (single row, zero rows,
// backpressure) followed by hand sequences for address wrap, command-while-busy and
// reset in the middle of a load.
module tb_weight_loader;
  import wbuf_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [15:0]  cfg_base_addr;
  logic [16:0]  cfg_rows;
  logic [255:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] data_wr;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_en;
  logic         busy;
  logic         done;

  weight_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_base_addr (cfg_base_addr),
    .cfg_rows      (cfg_rows),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .data_wr       (data_wr),
    .wr_addr       (wr_addr),
    .wr_en         (wr_en),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic         cv;
    logic [15:0]  base;
    logic [16:0]  rows;
    logic         sv;
    logic [255:0] sd;
    logic [31:0]  en;
    logic [15:0]  addr;
    logic [255:0] dat;
    logic         dn;
    logic         bz;
    logic         cr;
    logic         sr;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  logic [31:0] en_tab [8];
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] beat(input int t, input int k);
    logic [15:0] a;
    logic [15:0] b;
    a = t[15:0];
    b = k[15:0];
    return {8{a, b}};
  endfunction

  function automatic vec_t mk(input logic cv, input logic [15:0] base, input logic [16:0] rows,
                              input logic sv, input logic [255:0] sd, input logic [31:0] en,
                              input logic [15:0] addr, input logic [255:0] dat, input logic dn,
                              input logic bz, input logic cr, input logic sr);
    vec_t v;
    v.cv = cv; v.base = base; v.rows = rows; v.sv = sv; v.sd = sd;
    v.en = en; v.addr = addr; v.dat = dat; v.dn = dn; v.bz = bz; v.cr = cr; v.sr = sr;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    cfg_valid     = v.cv;
    cfg_base_addr = v.base;
    cfg_rows      = v.rows;
    s_valid       = v.sv;
    s_data        = v.sd;
    step();
    chk({tag, ".wr_en"},     256'(wr_en),     256'(v.en));
    chk({tag, ".wr_addr"},   256'(wr_addr),   256'(v.addr));
    chk({tag, ".data_wr"},   data_wr,         v.dat);
    chk({tag, ".done"},      256'(done),      256'(v.dn));
    chk({tag, ".busy"},      256'(busy),      256'(v.bz));
    chk({tag, ".cfg_ready"}, 256'(cfg_ready), 256'(v.cr));
    chk({tag, ".s_ready"},   256'(s_ready),   256'(v.sr));
  endtask

  initial begin
    logic [15:0]  la;
    logic [255:0] ld;
    int           n;
    int           en_cnt;
    int           pat [12];

    en_tab[0] = 32'h0000000F; en_tab[1] = 32'h000000F0;
    en_tab[2] = 32'h00000F00; en_tab[3] = 32'h0000F000;
    en_tab[4] = 32'h000F0000; en_tab[5] = 32'h00F00000;
    en_tab[6] = 32'h0F000000; en_tab[7] = 32'hF0000000;
    pat = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1};

    // ---------------- vector table ----------------
    la = 16'h0000;
    ld = '0;
    // Single row at 0x0010, eight back-to-back beats.
    tbl.push_back(mk(1'b1, 16'h0010, 17'd1, 1'b0, '0, '0, la, ld, 1'b0, 1'b1, 1'b0, 1'b1));
    for (int k = 0; k < 8; k++) begin
      la = 16'h0010;
      ld = beat(1, k);
      tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b1, ld, en_tab[k], la, ld, 1'b0, 1'b1, 1'b0, (k < 7)));
    end
    tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b0, '0, '0, la, ld, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b0, '0, '0, la, ld, 1'b0, 1'b0, 1'b1, 1'b0));
    // Zero rows: done next cycle, stream stays closed even with s_valid high.
    tbl.push_back(mk(1'b1, 16'h1234, 17'd0, 1'b1, beat(9, 0), '0, la, ld, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b1, beat(9, 1), '0, la, ld, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b1, beat(9, 2), '0, la, ld, 1'b0, 1'b0, 1'b1, 1'b0));
    // Backpressure: gaps carry junk data that must not be written.
    tbl.push_back(mk(1'b1, 16'h0200, 17'd1, 1'b0, '0, '0, la, ld, 1'b0, 1'b1, 1'b0, 1'b1));
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (pat[i] != 0) begin
        la = 16'h0200;
        ld = beat(2, n);
        tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b1, ld, en_tab[n], la, ld, 1'b0, 1'b1, 1'b0, (n < 7)));
        n++;
      end else begin
        tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b0, beat(3, i), '0, la, ld, 1'b0, 1'b1, 1'b0, 1'b1));
      end
    end
    tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b0, '0, '0, la, ld, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0000, 17'd0, 1'b0, '0, '0, la, ld, 1'b0, 1'b0, 1'b1, 1'b0));

    // ---------------- reset ----------------
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_base_addr = '0; cfg_rows = '0; s_valid = 1'b0; s_data = '0;
    step();
    step();
    chk("rst.wr_en",     256'(wr_en),     256'(32'h0));
    chk("rst.data_wr",   data_wr,         '0);
    chk("rst.wr_addr",   256'(wr_addr),   256'(16'h0));
    chk("rst.done",      256'(done),      256'(1'b0));
    chk("rst.busy",      256'(busy),      256'(1'b0));
    chk("rst.cfg_ready", 256'(cfg_ready), 256'(1'b1));
    chk("rst.s_ready",   256'(s_ready),   256'(1'b0));
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // ---------------- wrap: base 0xFFFF, 2 rows ----------------
    cfg_valid = 1'b1; cfg_base_addr = 16'hFFFF; cfg_rows = 17'd2; s_valid = 1'b0;
    step();
    cfg_valid = 1'b0;
    en_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      s_valid = 1'b1;
      s_data  = beat(4, k);
      step();
      if (wr_en != '0) en_cnt++;
      chk($sformatf("wrap.en%0d", k),   256'(wr_en),   256'(en_tab[k % 8]));
      chk($sformatf("wrap.addr%0d", k), 256'(wr_addr), 256'((k < 8) ? 16'hFFFF : 16'h0000));
    end
    s_valid = 1'b0;
    step();
    if (wr_en != '0) en_cnt++;
    chk("wrap.done", 256'(done), 256'(1'b1));
    step();
    if (wr_en != '0) en_cnt++;
    chk("wrap.idle", 256'(busy), 256'(1'b0));
    chk("wrap.en_count", 256'(en_cnt), 256'(16));

    // ---------------- command while busy ----------------
    cfg_valid = 1'b1; cfg_base_addr = 16'h0300; cfg_rows = 17'd1;
    step();
    cfg_base_addr = 16'h0400; cfg_rows = 17'd5;  // held high throughout the first load
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("cwb.cfg_ready%0d", k), 256'(cfg_ready), 256'(1'b0));
      s_valid = 1'b1;
      s_data  = beat(5, k);
      step();
      chk($sformatf("cwb.en%0d", k),   256'(wr_en),   256'(en_tab[k]));
      chk($sformatf("cwb.addr%0d", k), 256'(wr_addr), 256'(16'h0300));
    end
    s_valid = 1'b0;
    step();
    chk("cwb.done", 256'(done), 256'(1'b1));
    step();
    chk("cwb.idle_busy", 256'(busy),      256'(1'b0));
    chk("cwb.idle_rdy",  256'(cfg_ready), 256'(1'b1));
    step();
    chk("cwb.accepted", 256'(busy), 256'(1'b1));
    cfg_valid = 1'b0;

    // ---------------- reset after 3 of 8 beats ----------------
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = beat(6, k);
      step();
      chk($sformatf("rml.en%0d", k),   256'(wr_en),   256'(en_tab[k]));
      chk($sformatf("rml.addr%0d", k), 256'(wr_addr), 256'(16'h0400));
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rml.wr_en",     256'(wr_en),     256'(32'h0));
    chk("rml.busy",      256'(busy),      256'(1'b0));
    chk("rml.cfg_ready", 256'(cfg_ready), 256'(1'b1));
    chk("rml.done",      256'(done),      256'(1'b0));
    s_valid = 1'b0;
    step();
    chk("rml.no_done", 256'(done), 256'(1'b0));
    chk("rml.still_idle", 256'(busy), 256'(1'b0));
    cfg_valid = 1'b1; cfg_base_addr = 16'h0500; cfg_rows = 17'd1;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_valid = 1'b1;
      s_data  = beat(7, k);
      step();
      chk($sformatf("rml.re_en%0d", k),   256'(wr_en),   256'(en_tab[k]));
      chk($sformatf("rml.re_addr%0d", k), 256'(wr_addr), 256'(16'h0500));
      chk($sformatf("rml.re_dat%0d", k),  data_wr,       beat(7, k));
    end
    s_valid = 1'b0;
    step();
    chk("rml.re_done", 256'(done), 256'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
